// File: rtl/mesh_router_pkg.sv
// Shared constants and the XY routing function for the mesh router node.
// Port indices match the bit positions of the router's per-port vectors.
package mesh_router_pkg;

    localparam int NPORTS          = 5;
    localparam int COORD_W_DEFAULT = 4;

    localparam logic [2:0] P_L = 3'd0;
    localparam logic [2:0] P_N = 3'd1;
    localparam logic [2:0] P_E = 3'd2;
    localparam logic [2:0] P_S = 3'd3;
    localparam logic [2:0] P_W = 3'd4;

    // Dimension-ordered routing: X is resolved completely before Y, which is what keeps the mesh deadlock-free.
    function automatic logic [2:0] route_port(input logic [15:0] dest_x,
                                              input logic [15:0] dest_y,
                                              input logic [15:0] my_x,
                                              input logic [15:0] my_y);
        if (dest_x > my_x) begin
            return P_E;
        end else if (dest_x < my_x) begin
            return P_W;
        end else if (dest_y > my_y) begin
            return P_N;
        end else if (dest_y < my_y) begin
            return P_S;
        end
        return P_L;
    endfunction

endpackage

// File: rtl/mesh_router_fifo.sv
// Two-entry valid/ready input buffer. in_ready depends on occupancy only,
// so an upstream node never sees a combinational path through this router.
module mesh_router_fifo #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             in_ready_o,
    output logic             head_valid_o,
    output logic [WIDTH-1:0] head_data_o,
    input  logic             pop_i
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             push;
    logic             pop;

    assign in_ready_o   = (count_q != 2'd2);
    assign head_valid_o = (count_q != 2'd0);
    assign head_data_o  = mem_q[rd_ptr_q];

    assign push = in_valid_i && in_ready_o;
    assign pop  = pop_i && head_valid_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only visible while count_q covers it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data_i;
        end
    end

endmodule

// File: rtl/mesh_router.sv
// Five-port single-flit mesh router node: per-input 2-deep FIFOs, XY routing,
// and a round-robin arbiter feeding a registered stage on every output.
module mesh_router
    import mesh_router_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int COORD_W = COORD_W_DEFAULT,
    parameter int MY_X    = 0,
    parameter int MY_Y    = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NPORTS-1:0]         in_valid,
    input  logic [NPORTS*WIDTH-1:0]   in_data,
    output logic [NPORTS-1:0]         in_ready,
    output logic [NPORTS-1:0]         out_valid,
    output logic [NPORTS*WIDTH-1:0]   out_data,
    input  logic [NPORTS-1:0]         out_ready
);

    logic [NPORTS-1:0]              head_valid;
    logic [WIDTH-1:0]               head_data [NPORTS];
    logic [2:0]                     route     [NPORTS];
    logic [NPORTS-1:0][NPORTS-1:0]  req_mat;      // [output][input]
    logic [NPORTS-1:0]              grant     [NPORTS];
    logic [NPORTS-1:0]              pop;

    genvar gi;

    generate
        for (gi = 0; gi < NPORTS; gi++) begin : gen_in
            mesh_router_fifo #(
                .WIDTH (WIDTH)
            ) u_fifo (
                .clk          (clk),
                .rst_n        (rst_n),
                .in_valid_i   (in_valid[gi]),
                .in_data_i    (in_data[gi*WIDTH +: WIDTH]),
                .in_ready_o   (in_ready[gi]),
                .head_valid_o (head_valid[gi]),
                .head_data_o  (head_data[gi]),
                .pop_i        (pop[gi])
            );

            assign route[gi] = route_port(
                16'(head_data[gi][WIDTH-1 -: COORD_W]),
                16'(head_data[gi][WIDTH-1-COORD_W -: COORD_W]),
                16'(MY_X),
                16'(MY_Y));
        end
    endgenerate

    always_comb begin
        req_mat = '0;
        for (int o = 0; o < NPORTS; o++) begin
            for (int i = 0; i < NPORTS; i++) begin
                req_mat[o][i] = head_valid[i] && (route[i] == 3'(o));
            end
        end
    end

    // Each head requests one output only, so OR-ing the grant columns pops each input at most once.
    always_comb begin
        pop = '0;
        for (int o = 0; o < NPORTS; o++) begin
            pop = pop | grant[o];
        end
    end

    generate
        for (gi = 0; gi < NPORTS; gi++) begin : gen_out
            logic [2:0]        ptr_q, ptr_d;
            logic              out_valid_q, out_valid_d;
            logic [WIDTH-1:0]  out_data_q, out_data_d;
            logic              slot_free;
            logic              found;
            logic [2:0]        idx;
            logic [NPORTS-1:0] grant_loc;
            logic [WIDTH-1:0]  sel_data;

            assign slot_free = !out_valid_q || out_ready[gi];

            // Search starts just after the last winner; a held output issues no grant at all.
            always_comb begin
                grant_loc = '0;
                found     = 1'b0;
                idx       = 3'd0;
                ptr_d     = ptr_q;
                for (int k = 1; k <= NPORTS; k++) begin
                    idx = 3'((int'(ptr_q) + k) % NPORTS);
                    if (!found && slot_free && req_mat[gi][idx]) begin
                        grant_loc[idx] = 1'b1;
                        found          = 1'b1;
                        ptr_d          = idx;
                    end
                end
            end

            always_comb begin
                sel_data = '0;
                for (int i = 0; i < NPORTS; i++) begin
                    if (grant_loc[i]) begin
                        sel_data = sel_data | head_data[i];
                    end
                end
            end

            always_comb begin
                out_valid_d = out_valid_q;
                out_data_d  = out_data_q;
                if (slot_free) begin
                    out_valid_d = found;
                    if (found) begin
                        out_data_d = sel_data;
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ptr_q       <= 3'(NPORTS - 1);
                    out_valid_q <= 1'b0;
                    out_data_q  <= '0;
                end else begin
                    ptr_q       <= ptr_d;
                    out_valid_q <= out_valid_d;
                    out_data_q  <= out_data_d;
                end
            end

            assign grant[gi]                    = grant_loc;
            assign out_valid[gi]                = out_valid_q;
            assign out_data[gi*WIDTH +: WIDTH]  = out_data_q;
        end
    endgenerate

endmodule

// File: tb/tb_mesh_router.sv
// Directed bench for a mesh_router node at (1,1): routing, arbitration order,
// backpressure, throughput and asynchronous reset.
module tb_mesh_router;

    localparam int W = 32;
    localparam int N = 5;

    logic             clk;
    logic             rst_n;
    logic [N-1:0]     in_valid;
    logic [N*W-1:0]   in_data;
    logic [N-1:0]     in_ready;
    logic [N-1:0]     out_valid;
    logic [N*W-1:0]   out_data;
    logic [N-1:0]     out_ready;

    int checks = 0;
    int errors = 0;

    mesh_router #(
        .WIDTH   (W),
        .COORD_W (4),
        .MY_X    (1),
        .MY_Y    (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] od(input int p);
        return out_data[p*W +: W];
    endfunction

    task automatic put(input int p, input logic [W-1:0] d);
        in_valid[p]      = 1'b1;
        in_data[p*W +: W] = d;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        out_ready = '1;
        step();
        chk("reset_in_ready", 32'(in_ready), 32'h1F);
        chk("reset_out_valid", 32'(out_valid), 32'h0);
        chk("reset_out_data_E", od(2), 32'h0);
        rst_n = 1'b1;

        // Local delivery: accepted at edge k, visible after edge k+1.
        put(0, 32'h1100_00AB);
        step();
        in_valid = '0;
        chk("local_not_yet", 32'(out_valid), 32'h0);
        step();
        chk("local_valid", 32'(out_valid), 32'h01);
        chk("local_data", od(0), 32'h1100_00AB);
        step();
        chk("local_clear", 32'(out_valid), 32'h0);

        // XY order: X first, then Y.
        put(4, 32'h2000_0001);
        step(); in_valid = '0; step();
        chk("xy_20_port", 32'(out_valid), 32'h04);
        chk("xy_20_data", od(2), 32'h2000_0001);
        put(4, 32'h1000_0002);
        step(); in_valid = '0; step();
        chk("xy_10_port", 32'(out_valid), 32'h08);
        chk("xy_10_data", od(3), 32'h1000_0002);
        put(2, 32'h0100_0003);
        step(); in_valid = '0; step();
        chk("xy_01_port", 32'(out_valid), 32'h10);
        put(3, 32'h1200_0004);
        step(); in_valid = '0; step();
        chk("xy_12_port", 32'(out_valid), 32'h02);
        chk("xy_12_data", od(1), 32'h1200_0004);
        step();

        // Contention on E: L, N, W granted in index order.
        put(0, 32'h2000_00A1);
        put(1, 32'h2000_00B2);
        put(4, 32'h2000_00C3);
        step(); in_valid = '0;
        step();
        chk("rr_1st", od(2), 32'h2000_00A1);
        step();
        chk("rr_2nd", od(2), 32'h2000_00B2);
        step();
        chk("rr_3rd", od(2), 32'h2000_00C3);
        step();
        chk("rr_idle", 32'(out_valid), 32'h0);
        put(0, 32'h2000_00D4);
        put(4, 32'h2000_00E5);
        step(); in_valid = '0;
        step();
        chk("rr_next_1st", od(2), 32'h2000_00D4);
        step();
        chk("rr_next_2nd", od(2), 32'h2000_00E5);
        step();

        // Backpressure: 1 flit parked in the output register, 2 in the FIFO.
        out_ready[2] = 1'b0;
        put(0, 32'h2000_0011);
        step();
        put(0, 32'h2000_0022);
        step();
        chk("bp_reg_valid", 32'(out_valid), 32'h04);
        chk("bp_reg_data", od(2), 32'h2000_0011);
        chk("bp_ready_after2", 32'(in_ready[0]), 32'h1);
        put(0, 32'h2000_0033);
        step();
        in_valid = '0;
        chk("bp_ready_full", 32'(in_ready[0]), 32'h0);
        step();
        chk("bp_hold_data", od(2), 32'h2000_0011);
        chk("bp_hold_ready", 32'(in_ready[0]), 32'h0);
        out_ready[2] = 1'b1;
        step();
        chk("bp_drain_2", od(2), 32'h2000_0022);
        chk("bp_ready_back", 32'(in_ready[0]), 32'h1);
        step();
        chk("bp_drain_3", od(2), 32'h2000_0033);
        step();
        chk("bp_idle", 32'(out_valid), 32'h0);

        // Throughput: one flit per cycle, in_ready never drops.
        for (int i = 0; i < 6; i++) begin
            put(0, 32'h2000_0100 + 32'(i));
            step();
            chk("tp_ready", 32'(in_ready[0]), 32'h1);
            if (i > 0) begin
                chk("tp_data", od(2), 32'h2000_0100 + 32'(i - 1));
            end
        end
        in_valid = '0;
        step();
        chk("tp_last", od(2), 32'h2000_0105);
        step();
        chk("tp_idle", 32'(out_valid), 32'h0);

        // Asynchronous reset with flits in both the output register and the FIFO.
        out_ready[2] = 1'b0;
        put(0, 32'h2000_0AA1);
        step();
        put(0, 32'h2000_0AA2);
        step();
        in_valid = '0;
        chk("mid_loaded", od(2), 32'h2000_0AA1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_out_valid", 32'(out_valid), 32'h0);
        chk("async_out_data", od(2), 32'h0);
        chk("async_in_ready", 32'(in_ready), 32'h1F);
        step();
        rst_n = 1'b1;
        out_ready = '1;
        step();
        step();
        chk("post_reset_discard", 32'(out_valid), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
